// File: rtl/seg7_scan_driver_if.sv
// Bundles the load-side word and the scanned segment/anode pins of seg7_scan_driver.
// Latency: none, wires only.
// Backpressure: none; load is a fire-and-forget strobe. Define SEG7_BLINK_EN to add the blink mask.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    // Load side: the word that is captured into the pending buffer
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     en;
    logic [DIGITS-1:0]     dp;
`ifdef SEG7_BLINK_EN
    logic [DIGITS-1:0]     blink;
`endif

    // Display side: registered pin drives and status
    logic [6:0]            seg;
    logic                  dp_o;
    logic [DIGITS-1:0]     an;
    logic                  frame_tick;
    logic                  pending;

`ifdef SEG7_BLINK_EN
    modport master (
        output load, value, en, dp, blink,
        input  seg, dp_o, an, frame_tick, pending
    );
    modport slave (
        input  load, value, en, dp, blink,
        output seg, dp_o, an, frame_tick, pending
    );
`else
    modport master (
        output load, value, en, dp,
        input  seg, dp_o, an, frame_tick, pending
    );
    modport slave (
        input  load, value, en, dp,
        output seg, dp_o, an, frame_tick, pending
    );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for DIGITS 7-segment digits; double-buffered, tear-free updates.
// Latency: pins are registered one cycle behind the scan counters; load reaches the display at the next frame boundary.
// Backpressure: none; load is always accepted, the last load before a boundary wins. Optional blink: SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int DIGITS         = 8,    // 2..16
    parameter int SCAN_DIV       = 1000, // cycles per digit, >= 2
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLINK_FRAMES   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Polarity masks: the decode is active-high, these flip it to pin level
    localparam logic [6:0]        SEG_XOR  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_XOR   = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_XOR   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // One displayable word; the same layout is used for the pending and display buffers
    typedef struct packed {
`ifdef SEG7_BLINK_EN
        logic [DIGITS-1:0]   blink;
`endif
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   en;
        logic [4*DIGITS-1:0] value;
    } word_t;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] font(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              cnt_last;
    logic              idx_last;
    logic              boundary;

    word_t             load_word;
    word_t             pend_q;
    word_t             disp_q;
    logic              pend_vld;

    logic [3:0]        nib;
    logic              lit;
    logic [6:0]        seg_lit;
    logic              dp_lit;
    logic [DIGITS-1:0] an_sel;

    assign cnt_last = (cnt == CNT_LAST);
    assign idx_last = (idx == IDX_LAST);
    // Last cycle of the last digit: the display buffer may only change on this edge
    assign boundary = cnt_last & idx_last;

    // Gather the load-side fields into a buffer word
    always_comb begin
        load_word       = '0;
        load_word.value = bus.value;
        load_word.en    = bus.en;
        load_word.dp    = bus.dp;
`ifdef SEG7_BLINK_EN
        load_word.blink = bus.blink;
`endif
    end

    // Dwell counter and digit index; idx advances once per SCAN_DIV cycles and wraps after DIGITS-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx_last ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: loads land in pending, the display copies pending only at a frame boundary.
    // A load on the boundary edge itself is kept pending; the copy uses the older word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            disp_q   <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (boundary && pend_vld) begin
                disp_q <= pend_q;
            end
            if (bus.load) begin
                pend_q   <= load_word;
                pend_vld <= 1'b1;
            end else if (boundary) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] frame_cnt;
    logic            phase;

    // Blink phase flips every BLINK_FRAMES frames; phase 0 is the visible half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + BF_W'(1);
            end
        end
    end
`endif

    // Decode the digit currently selected by idx, active-high, blanked digits fully dark
    always_comb begin
        nib = disp_q.value[{idx, 2'b00} +: 4];
        lit = disp_q.en[idx];
`ifdef SEG7_BLINK_EN
        if (disp_q.blink[idx] && phase) begin
            lit = 1'b0;
        end
`endif
        seg_lit = lit ? font(nib) : 7'h00;
        dp_lit  = lit & disp_q.dp[idx];
        an_sel  = lit ? ({{(DIGITS-1){1'b0}}, 1'b1} << idx) : {DIGITS{1'b0}};
    end

    // Pin registers: polarity applied after decode so the pins never glitch between digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg        <= SEG_XOR;
            bus.dp_o       <= DP_XOR;
            bus.an         <= AN_XOR;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.seg        <= seg_lit ^ SEG_XOR;
            bus.dp_o       <= dp_lit ^ DP_XOR;
            bus.an         <= an_sel ^ AN_XOR;
            bus.frame_tick <= boundary;
        end
    end

    assign bus.pending = pend_vld;

endmodule
